// File: rtl/ea_unit_if.sv
// ea_unit_if: request/result handshake and main-memory bus of the effective-address unit.
// master = the ea_unit side, slave = the requester/memory side.
interface ea_unit_if #(parameter int WORD_W = 12);
  logic              start;
  logic [WORD_W-1:0] ir;
  logic [WORD_W-1:0] instr_pc;
  logic [WORD_W-1:0] ea;
  logic              busy;
  logic              done;
  logic [WORD_W-1:0] mem_address;
  logic              mem_read_enable;
  logic              mem_write_enable;
  logic [WORD_W-1:0] mem_write_data;
  logic [WORD_W-1:0] mem_read_data;
  logic              mem_finished;
  logic              read_type;
  modport master (
    input  start, ir, instr_pc, mem_read_data, mem_finished,
    output ea, busy, done, mem_address, mem_read_enable, mem_write_enable, mem_write_data, read_type
  );
  modport slave (
    output start, ir, instr_pc, mem_read_data, mem_finished,
    input  ea, busy, done, mem_address, mem_read_enable, mem_write_enable, mem_write_data, read_type
  );
endinterface

// File: rtl/ea_unit.sv
// ea_unit: PDP-8 effective-address calculator (direct, current-page, indirect, autoindex).
// Define AUTOINDEX_EN to enable the 0010-0017 autoincrement write-back.
module ea_unit #(
  parameter int WORD_W = 12
) (
  input  logic      clk,
  input  logic      reset_n,
  ea_unit_if.master bus
);
  localparam logic DATA_READ = 1'b0;
  typedef enum logic [2:0] {
    IDLE,
    CALC,
    IND_READ,
`ifdef AUTOINDEX_EN
    AUTO_WRITE,
`endif
    DONE
  } state_t;
  state_t            state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d, ea_q, ea_d, dir;
  logic [WORD_W-8:0] page_q, page_d;
  logic              opr;
`ifdef AUTOINDEX_EN
  logic [WORD_W-1:0] ptr_q, ptr_d, ptr_inc;
  logic              auto_addr;
  assign ptr_inc   = ptr_q + WORD_W'(1);
  assign auto_addr = dir[WORD_W-1:3] == (WORD_W-3)'(1);
`endif
  assign dir = ir_q[7] ? {page_q, ir_q[6:0]} : {{(WORD_W-7){1'b0}}, ir_q[6:0]};
  assign opr = ir_q[WORD_W-1:WORD_W-2] == 2'b11;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      page_q  <= '0;
      ea_q    <= '0;
`ifdef AUTOINDEX_EN
      ptr_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      page_q  <= page_d;
      ea_q    <= ea_d;
`ifdef AUTOINDEX_EN
      ptr_q   <= ptr_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    page_d  = page_q;
    ea_d    = ea_q;
`ifdef AUTOINDEX_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = CALC;
        ir_d    = bus.ir;
        page_d  = bus.instr_pc[WORD_W-1:7];
      end
      CALC: begin
        state_d = (ir_q[8] && !opr) ? IND_READ : DONE;
        ea_d    = opr ? '0 : ir_q[8] ? ea_q : dir;
      end
      IND_READ: if (bus.mem_finished) begin
`ifdef AUTOINDEX_EN
        ptr_d   = bus.mem_read_data;
        state_d = auto_addr ? AUTO_WRITE : DONE;
        ea_d    = auto_addr ? ea_q : bus.mem_read_data;
`else
        state_d = DONE;
        ea_d    = bus.mem_read_data;
`endif
      end
`ifdef AUTOINDEX_EN
      AUTO_WRITE: if (bus.mem_finished) begin
        state_d = DONE;
        ea_d    = ptr_inc;
      end
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // Bus strobes decode straight from the state register, so reset drops them at once.
  assign bus.ea              = ea_q;
  assign bus.busy            = state_q != IDLE;
  assign bus.done            = state_q == DONE;
  assign bus.read_type       = DATA_READ;
  assign bus.mem_read_enable = state_q == IND_READ;
`ifdef AUTOINDEX_EN
  assign bus.mem_write_enable = state_q == AUTO_WRITE;
  assign bus.mem_write_data   = bus.mem_write_enable ? ptr_inc : '0;
  assign bus.mem_address      = (bus.mem_read_enable || bus.mem_write_enable) ? dir : '0;
`else
  assign bus.mem_write_enable = 1'b0;
  assign bus.mem_write_data   = '0;
  assign bus.mem_address      = bus.mem_read_enable ? dir : '0;
`endif
endmodule

// File: tb/tb_ea_unit.sv
// tb_ea_unit: randomized self-checking bench for ea_unit with a behavioural memory and address model.
module tb_ea_unit;
  localparam int W = 12;
`ifdef AUTOINDEX_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  ea_unit_if #(.WORD_W(W)) bus ();
  ea_unit #(.WORD_W(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_err = 0;
  int lat = 0, both_hi = 0, idle_en = 0, unstable = 0;
  logic [W-1:0] mem [4096];
  logic [W-1:0] rd_q[$], wa_q[$], wd_q[$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // memory slave: completes each access after lat wait cycles, noise on mem_finished when idle
  initial begin
    bit active;
    int cnt;
    logic [W-1:0] a0;
    active = 0; cnt = 0; a0 = '0;
    bus.mem_finished = 1'b0;
    bus.mem_read_data = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read_enable && bus.mem_write_enable) both_hi++;
      if (!bus.busy && (bus.mem_read_enable || bus.mem_write_enable)) idle_en++;
      if (bus.mem_read_enable || bus.mem_write_enable) begin
        if (!active) begin active = 1; cnt = lat; a0 = bus.mem_address; end
        else if (bus.mem_address !== a0) unstable++;
        if (cnt == 0) begin
          if (bus.mem_read_enable) begin
            bus.mem_read_data = mem[bus.mem_address];
            rd_q.push_back(bus.mem_address);
          end else begin
            mem[bus.mem_address] = bus.mem_write_data;
            wa_q.push_back(bus.mem_address);
            wd_q.push_back(bus.mem_write_data);
          end
          bus.mem_finished = 1'b1;
          active = 0;
        end else begin
          cnt--;
          bus.mem_finished = 1'b0;
          bus.mem_read_data = W'($urandom);
        end
      end else begin
        active = 0;
        bus.mem_finished = ($urandom_range(3) == 0);
        bus.mem_read_data = W'($urandom);
      end
    end
  end
  task automatic run(input logic [W-1:0] ir, input logic [W-1:0] pc, input bit noise);
    logic [W-1:0] dir, ptr, ea_x, wexp;
    int cyc, ncyc, nrd, nwr;
    dir = ir[7] ? ((pc & 12'hF80) | (ir & 12'h07F)) : (ir & 12'h07F);
    ptr = mem[dir];
    wexp = W'((int'(ptr) + 1) % 4096);
    nrd = 0; nwr = 0; ncyc = 2;
    if (int'(ir[11:9]) >= 6) ea_x = '0;
    else if (!ir[8]) ea_x = dir;
    else begin
      nrd = 1;
      ncyc = 3 + lat;
      if (AUTO && dir >= 8 && dir <= 15) begin
        nwr = 1; ea_x = wexp; ncyc = 4 + 2 * lat;
      end else ea_x = ptr;
    end
    rd_q.delete(); wa_q.delete(); wd_q.delete();
    @(negedge clk);
    bus.start = 1'b1; bus.ir = ir; bus.instr_pc = pc;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      bus.start = noise ? 1'($urandom_range(1)) : 1'b0;
      bus.ir = W'($urandom);
      bus.instr_pc = W'($urandom);
    end while (!bus.done && cyc < 200);
    chk("done_seen", bus.done, 1);
    chk("latency", cyc, ncyc);
    chk("ea", bus.ea, ea_x);
    chk("busy_in_done", bus.busy, 1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("done_pulse", bus.done, 0);
    chk("idle_after", bus.busy, 0);
    chk("ea_hold", bus.ea, ea_x);
    chk("reads", rd_q.size(), nrd);
    chk("writes", wa_q.size(), nwr);
    if (rd_q.size() == 1 && nrd == 1) chk("rd_addr", rd_q[0], dir);
    if (wa_q.size() == 1 && nwr == 1) begin
      chk("wr_addr", wa_q[0], dir);
      chk("wr_data", wd_q[0], wexp);
    end
    if (nrd == 1) chk("mem_after", mem[dir], nwr ? wexp : ptr);
  endtask
  initial begin
    logic [W-1:0] ir;
    bus.start = 1'b0; bus.ir = '0; bus.instr_pc = '0;
    foreach (mem[i]) mem[i] = W'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ea", bus.ea, 0);
    chk("rst_addr", bus.mem_address, 0);
    chk("rst_wdata", bus.mem_write_data, 0);
    chk("rst_ren", bus.mem_read_enable, 0);
    chk("rst_wen", bus.mem_write_enable, 0);
    chk("rst_rtype", bus.read_type, 0);
    reset_n = 1'b1;
    lat = 0;
    run(12'h045, 12'h2A0, 0);
    run(12'h0C5, 12'h2A0, 0);
    mem[12'h030] = 12'h7F2;
    run(12'h130, 12'h2A0, 0);
    mem[12'h00A] = 12'hFFF;
    run(12'h10A, 12'h2A0, 0);
    lat = 5;
    mem[12'h030] = 12'h123;
    run(12'h130, 12'h000, 1);
    lat = 2;
    mem[12'h00C] = 12'h456;
    run(12'h10C, 12'h000, 1);
    lat = 20;
    @(negedge clk);
    bus.start = 1'b1; bus.ir = 12'h130; bus.instr_pc = '0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 10 && !bus.mem_read_enable; k++) @(negedge clk);
    chk("rst_rd_seen", bus.mem_read_enable, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_ren", bus.mem_read_enable, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ea", bus.ea, 0);
    chk("mid_rst_addr", bus.mem_address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    lat = 1;
    run(12'h130, 12'h000, 0);
    run(12'hC45, 12'h2A0, 0);
    run(12'hF80, 12'h7A0, 1);
    repeat (150) begin
      lat = $urandom_range(3);
      ir = W'($urandom);
      if ($urandom_range(3) == 0) ir = (ir & 12'hE00) | 12'h100 | W'($urandom_range(8, 15));
      run(ir, W'($urandom), 1'($urandom_range(1)));
    end
    chk("both_enables", both_hi, 0);
    chk("idle_enables", idle_en, 0);
    chk("addr_stable", unstable, 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
